// File: rtl/param_sequence_detector.sv
// Serial pattern detector: walks a 1-bit memory, slides a PAT_LEN-bit window over the stream
// and counts pattern occurrences, with a saturating count and a clamped 4-digit BCD view.
module param_sequence_detector #(
  parameter int unsigned PAT_LEN   = 4,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned MEM_DEPTH = 16,
  parameter int unsigned CNT_W     = 14,
  parameter int unsigned TICK_DIV  = 100000000
) (
  input  logic               clock_100Mhz,
  input  logic               reset,
  input  logic               start,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic               overlap,
  input  logic               mem_bit,
  output logic               mem_en,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               busy,
  output logic               done,
  output logic               match_pulse,
  output logic [CNT_W-1:0]   match_count,
  output logic [ADDR_W-1:0]  last_match_addr,
  output logic [15:0]        bcd_digits
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned FillW = $clog2(PAT_LEN + 1);
  localparam int unsigned ExtW  = (CNT_W > 14) ? CNT_W : 14;

  typedef enum logic [2:0] {StIdle, StFetch, StWait, StCompare, StDone} state_e;

  state_e             state_q, state_d;
  logic [TickW-1:0]   tick_cnt_q;
  logic               tick;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [PAT_LEN-1:0] pattern_q, pattern_d;
  logic               overlap_q, overlap_d;
  // Only PAT_LEN-1 bits of history are kept; the newest bit comes straight from mem_bit.
  logic [PAT_LEN-2:0] window_q, window_d;
  logic [FillW-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]  last_q, last_d;
  logic               pulse_q, pulse_d;

  logic [PAT_LEN-1:0] win_next;
  logic [FillW-1:0]   fill_next;
  logic               is_match;

  // Free-running step divider, cleared only by reset.
  assign tick = (tick_cnt_q == TickW'(TICK_DIV - 1));

  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  assign win_next  = {window_q, mem_bit};
  assign fill_next = (fill_q == FillW'(PAT_LEN)) ? fill_q : fill_q + 1'b1;
  assign is_match  = (fill_next == FillW'(PAT_LEN)) && (win_next == pattern_q);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    pattern_d = pattern_q;
    overlap_d = overlap_q;
    window_d  = window_q;
    fill_d    = fill_q;
    count_d   = count_q;
    last_d    = last_q;
    pulse_d   = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          pattern_d = pattern;
          overlap_d = overlap;
          count_d   = '0;
          last_d    = '0;
          window_d  = '0;
          fill_d    = '0;
          addr_d    = '0;
          state_d   = StFetch;
        end
      end
      StFetch: begin
        if (tick) begin
          state_d = StWait;
        end
      end
      StWait: begin
        state_d = StCompare;
      end
      StCompare: begin
        window_d = win_next[PAT_LEN-2:0];
        fill_d   = fill_next;
        if (is_match) begin
          pulse_d = 1'b1;
          if (count_q != '1) begin
            count_d = count_q + 1'b1;
          end
          last_d = addr_q;
          // Non-overlapping mode restarts the fill so matched bits are not reused.
          if (!overlap_q) begin
            fill_d = '0;
          end
        end
        if (addr_q == ADDR_W'(MEM_DEPTH - 1)) begin
          state_d = StDone;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = StFetch;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      pattern_q <= '0;
      overlap_q <= 1'b0;
      window_q  <= '0;
      fill_q    <= '0;
      count_q   <= '0;
      last_q    <= '0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      pattern_q <= pattern_d;
      overlap_q <= overlap_d;
      window_q  <= window_d;
      fill_q    <= fill_d;
      count_q   <= count_d;
      last_q    <= last_d;
      pulse_q   <= pulse_d;
    end
  end

  assign mem_en          = (state_q == StFetch) && tick;
  assign mem_addr        = addr_q;
  assign busy            = (state_q == StFetch) || (state_q == StWait) || (state_q == StCompare);
  assign done            = (state_q == StDone);
  assign match_pulse     = pulse_q;
  assign match_count     = count_q;
  assign last_match_addr = last_q;

  logic [ExtW-1:0] cnt_ext;
  logic [13:0]     clamped;
  logic [15:0]     bcd;

  assign cnt_ext = ExtW'(count_q);
  assign clamped = (cnt_ext > ExtW'(9999)) ? 14'd9999 : cnt_ext[13:0];

  // Double-dabble conversion of the clamped count.
  always_comb begin
    bcd = '0;
    for (int i = 13; i >= 0; i--) begin
      for (int d = 0; d < 4; d++) begin
        if (bcd[d*4 +: 4] >= 4'd5) begin
          bcd[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
        end
      end
      bcd = {bcd[14:0], clamped[i]};
    end
  end

  assign bcd_digits = bcd;

endmodule

// File: doc/param_sequence_detector.md
# param_sequence_detector

Parametrised serial-pattern detector that walks a single-bit block memory, slides a PAT_LEN-bit window over the stream and counts pattern occurrences. It supports runtime-selected patterns and an overlapping or non-overlapping match mode. A start/busy/done handshake controls each run. The block sits between the block-RAM instance and the seven-segment display controller, and supplies a clamped 4-digit BCD count for the display.

## Interface
Parameters:
- PAT_LEN, 4: pattern length in bits, range 2..16.
- ADDR_W, 4: memory address width.
- MEM_DEPTH, 16: bits scanned per run, addresses 0..MEM_DEPTH-1, at most 2^ADDR_W.
- CNT_W, 14: match counter width.
- TICK_DIV, 100000000: clocks per step tick, at least 1. A value of 1 means every cycle.

Ports (clock and reset first):
- clock_100Mhz in 1: single system clock, rising edge.
- reset in 1: asynchronous, active-low reset. Port name is kept as in the codebase; polarity and synchronicity are fixed: asserted when 0.
- start in 1: run request, level-sampled in IDLE/DONE.
- pattern in PAT_LEN: pattern to detect. pattern[PAT_LEN-1] is the first bit in stream order. Latched on accepted start.
- overlap in 1: 1 selects overlapping mode, 0 selects non-overlapping. Latched on accepted start.
- mem_bit in 1: memory read data, valid 2 cycles after mem_en.
- mem_en out 1: memory read enable, one-cycle strobe.
- mem_addr out ADDR_W: memory read address, registered.
- busy out 1: high in FETCH/WAIT/COMPARE.
- done out 1: high in DONE.
- match_pulse out 1: one-cycle pulse per detected match.
- match_count out CNT_W: matches in the current/last run, saturating.
- last_match_addr out ADDR_W: address of the final bit of the most recent match.
- bcd_digits out 16: {thousands, hundreds, tens, ones} of min(match_count, 9999).

## Operation
- FSM states: IDLE, FETCH, WAIT, COMPARE, DONE.
- IDLE/DONE, start=1:
  - latch pattern and overlap;
  - clear match_count, last_match_addr, window and fill counter;
  - set addr=0;
  - go to FETCH.
- start in FETCH/WAIT/COMPARE is ignored.
- FETCH: waits for tick. On tick, mem_en=1 (combinational: FETCH && tick) with mem_addr=addr, then go to WAIT.
- WAIT: one cycle, then COMPARE.
- COMPARE:
  - window <= {window[PAT_LEN-2:0], mem_bit};
  - fill <= min(fill+1, PAT_LEN).
  - A match occurs when the new fill == PAT_LEN and the new window == latched pattern.
  - On a match:
    - match_pulse=1 next cycle;
    - match_count += 1, saturating at 2^CNT_W-1;
    - last_match_addr = addr;
    - in non-overlap mode, fill <= 0.
  - If addr == MEM_DEPTH-1, go to DONE; otherwise addr+1 and go to FETCH.
- DONE: done=1, results held until the next accepted start.
- Tick divider: free-running counter 0..TICK_DIV-1; tick=1 when the count is TICK_DIV-1. It runs in all states and is cleared only by reset.
- BCD: combinational from the clamped count. A count above 9999 displays 9999.

## Timing
- Reset (reset=0) takes effect asynchronously and forces the following values:
  - state IDLE;
  - mem_en=0, mem_addr=0, busy=0, done=0, match_pulse=0;
  - match_count=0, last_match_addr=0, bcd_digits=16'h0000;
  - tick counter=0, window=0, fill=0.
- Reset mid-run aborts immediately with no DONE. After release, the block waits for start.
- Start accepted at edge k: busy=1 after edge k.
- With TICK_DIV=1, each bit costs 3 cycles (FETCH, WAIT, COMPARE). A full run is 3*MEM_DEPTH cycles from FETCH entry to DONE entry.
- Match timing: match_pulse, match_count and last_match_addr update on the same edge, the one that leaves COMPARE.
- The last bit's match is counted before done rises: done and the final match_pulse appear together.
- Simultaneous start and reset: reset wins.
- Patterns are never matched across runs, because window and fill clear on start.

## Test plan
Common setup unless stated otherwise: TICK_DIV=1, PAT_LEN=4, memory addresses 0..15 = 1,0,1,1,0,1,1,0,1,1,1,0,1,1,0,0.
- Overlap: pattern=1011, overlap=1, start → match_pulse at addresses 3, 6, 9, 13. At DONE: match_count=4, last_match_addr=13, bcd_digits=16'h0004. done occurs 48 cycles after FETCH entry.
- Non-overlap: same memory, overlap=0 → matches at 3, 9, 13. At DONE: match_count=3, last_match_addr=13.
- Handshake: start held high throughout the run → no restart while busy. Start high in DONE → count clears to 0 and a new run begins. Changing pattern mid-run has no effect.
- Reset mid-run: assert reset=0 at address 7, asynchronously between edges → all outputs go to reset values immediately. After release, the block stays in IDLE until start.
- Saturation/BCD: CNT_W=4, memory all 1, pattern=1111, overlap=1 → 13 raw matches, match_count=13, bcd_digits=16'h0013. Repeat with CNT_W=3 → count saturates at 7.
- Tick pacing: TICK_DIV=5 → mem_en pulses exactly 5 cycles apart and the run completes with the same results as the overlap scenario.
